clk_div_ctrl: RTL
=================

# clk_div_ctrl

Programmable clock-divider controller for the Zynq fabric logic. It generates a divided square wave `clkout` and a matching one-cycle `tick` enable from `clkin`. The divide ratio can be changed at runtime through a valid/ready config port and takes effect only at a `clkout` rising edge, so no runt pulses are produced. Start and stop are also glitch-free. It replaces fixed divide-by-16 dividers wherever downstream logic (DAC/ADC strobes, display scan) needs a software-set rate.

## Interface
- `CNT_W`, default 16: width of the half-period counter and config word.
- `DIV_RESET`, default 7: half-period minus one loaded at reset. Default gives `clkout` = `clkin`/16.
- `clkin`, in, 1: the single clock. All logic is on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `run`, in, 1: level. 1 = generate `clkout`; 0 = stop cleanly.
- `cfg_valid`, in, 1: a new half-period value is offered.
- `cfg_half`, in, `CNT_W`: new half-period minus one. Half period H = `cfg_half`+1 cycles.
- `cfg_ready`, out, 1: the controller can accept a config word.
- `clkout`, out, 1: divided clock, registered. Period is 2·H `clkin` cycles.
- `tick`, out, 1: registered. High for exactly the one cycle in which `clkout` goes 0→1.
- `active`, out, 1: 1 in RUN or STOP state.

## Operation
- Registers:
  - `state` ∈ {IDLE, RUN, STOP}
  - `cnt` [`CNT_W`]
  - `half_q` [`CNT_W`]: active ratio
  - `pend_q` [`CNT_W`] and `pend_v`: pending ratio and its valid flag
- Reset values:
  - state = IDLE, `cnt`=0, `half_q`=`DIV_RESET`, `pend_v`=0
  - `clkout`=0, `tick`=0, `active`=0, `cfg_ready`=1
- `cfg_ready` = ~`pend_v`. A config is accepted on a cycle with `cfg_valid`&&`cfg_ready`: `pend_q`←`cfg_half`, `pend_v`←1. At most one word is pending; the next word waits until the pending one is applied.
- **IDLE**:
  - `clkout`=0, `cnt`=0.
  - If `pend_v`: `half_q`←`pend_q`, `pend_v`←0.
  - If `run`: next cycle `clkout`←1, `tick`←1, `cnt`←0, state←RUN. A pending word applies on this same edge.
- **RUN**:
  - If `cnt`==`half_q`: `cnt`←0 and `clkout`←~`clkout`. If this is a 0→1 toggle: `tick`←1, and if `pend_v` then `half_q`←`pend_q`, `pend_v`←0.
  - Otherwise `cnt`←`cnt`+1 and `tick`←0.
  - If `run`=0: state←STOP, and the current half continues counting.
- **STOP**:
  - Counting continues.
  - At `cnt`==`half_q`: `clkout`←0 (no rising edge is ever issued), `cnt`←0, state←IDLE.
  - If `run` returns to 1 before that point: state←RUN with no interruption to `cnt` or `clkout`.
- `cfg_half`=0 gives H=1, i.e. `clkout` = `clkin`/2, and `tick` is high every other cycle.
- `cnt` never exceeds `half_q`. No wrap at 2^`CNT_W`. All-ones `cfg_half` is legal (H=2^`CNT_W`).

## Timing
- `run` rising in IDLE → `clkout`=1 and `tick`=1 one cycle later.
- In steady state:
  - High phase is exactly H cycles, low phase is exactly H cycles.
  - `tick` period is 2·H.
- A new ratio applies from the first rising edge after acceptance:
  - The current full period finishes at the old ratio.
  - Worst-case latency from acceptance to effect is 2·H_old cycles.
- `run` falling:
  - `clkout` returns to 0 at the end of the current half, after at most H cycles.
  - `active` drops on the same edge.
- `rst` mid-operation returns all registers to reset values on the next edge. Any pending config is discarded.

## Structure
- Package `clk_div_pkg` holds:
  - the state enum `clk_div_state_t` (IDLE, RUN, STOP)
  - `CLK_DIV_CNT_W_DEF`=16
  - `CLK_DIV_RESET_DEF`=7
- One sub-module is natural: `clk_div_core`. It contains the `cnt`/`half_q` compare and the `clkout`/`tick` toggle, with a `load`/`load_val` input and an `en` input.
- `clk_div_ctrl` holds the FSM, the pending register and the handshake.

## Test plan
- Reset, then `run`=1 held with defaults → `clkout` period 16, high for 8 cycles; `tick` every 16 cycles, coincident with `clkout` rising.
- `cfg_half`=0 while IDLE, then `run`=1 → `clkout` toggles every cycle and `tick` is high every 2nd cycle.
- Running at H=8, accept `cfg_half`=2 mid-high-phase → current period completes as 8+8; from the next rise `clkout` runs 3+3. `cfg_ready` is low from the accept until that rise.
- Second `cfg_valid` while `pend_v`=1 → not accepted (`cfg_ready`=0); accepted the cycle after the apply.
- `run` dropped 2 cycles into a high phase, H=8 → `clkout` falls 6 cycles later and `active`=0 on that edge. `run` dropped during a low phase → `clkout` stays 0 and no `tick` occurs.
- `rst` asserted mid-RUN with a pending config → next cycle: `clkout`=0, `tick`=0, `cfg_ready`=1, ratio back to 7.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and defaults for the programmable clock divider.
// Holds the controller state enum and the default counter width / reset ratio.
// No ports; imported by clk_div_core and clk_div_ctrl.
package clk_div_pkg;

  localparam int CLK_DIV_CNT_W_DEF = 16;
  // Half-period minus one; 7 gives clkout = clkin / 16.
  localparam int CLK_DIV_RESET_DEF = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } clk_div_state_t;

endpackage

// File: rtl/clk_div_core.sv
// clk_div_core: half-period counter and clkout/tick toggle for the divider.
// Latency: start -> clkout/tick high on the next edge; toggles registered.
// Backpressure: none; the controller steers it with start/en/no_rise/load.
// Ports:
//   clkin, rst        clock and synchronous active-high reset
//   en                count and toggle at the half-period boundary
//   start             force a rising edge next cycle (cnt restarts at 0)
//   no_rise           at the boundary, drive clkout low instead of toggling
//   load, load_val    replace the active half-period (minus one)
//   wrap              cnt has reached the active half-period
//   clkout, tick      divided clock and its one-cycle rising-edge strobe
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int          CNT_W     = CLK_DIV_CNT_W_DEF,
  parameter int unsigned DIV_RESET = CLK_DIV_RESET_DEF
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             no_rise,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             wrap,
  output logic             clkout,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half_q;

  // cnt is reset to 0 at every boundary, so it never exceeds half_q and
  // an all-ones half_q simply counts the full 2^CNT_W cycles.
  assign wrap = (cnt == half_q);

  always_ff @(posedge clkin) begin
    if (rst) begin
      cnt    <= '0;
      half_q <= CNT_W'(DIV_RESET);
      clkout <= 1'b0;
      tick   <= 1'b0;
    end else begin
      if (load) begin
        half_q <= load_val;
      end
      if (start) begin
        cnt    <= '0;
        clkout <= 1'b1;
        tick   <= 1'b1;
      end else if (en) begin
        if (wrap) begin
          cnt <= '0;
          if (no_rise) begin
            // Stopping: end the current half low, never issue a rising edge.
            clkout <= 1'b0;
            tick   <= 1'b0;
          end else begin
            clkout <= ~clkout;
            tick   <= ~clkout;
          end
        end else begin
          cnt  <= cnt + CNT_W'(1);
          tick <= 1'b0;
        end
      end else begin
        cnt    <= '0;
        clkout <= 1'b0;
        tick   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run/stop FSM and ratio update handshake around clk_div_core.
// Latency: run rise in IDLE -> clkout/tick high next cycle; new ratio at next clkout rise.
// Backpressure: cfg_ready low while one ratio word is pending application.
// Ports:
//   clkin, rst            clock and synchronous active-high reset
//   run                   level: 1 generates clkout, 0 stops at the end of the half
//   cfg_valid, cfg_half   offered half-period minus one
//   cfg_ready             a config word can be accepted this cycle
//   clkout, tick          divided clock and rising-edge strobe
//   active                controller is in RUN or STOP
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int          CNT_W     = CLK_DIV_CNT_W_DEF,
  parameter int unsigned DIV_RESET = CLK_DIV_RESET_DEF
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             clkout,
  output logic             tick,
  output logic             active
);

  clk_div_state_t   state, state_n;
  logic [CNT_W-1:0] pend_q;
  logic             pend_v;

  logic core_en, core_start, core_no_rise, apply, wrap;

  assign cfg_ready = ~pend_v;
  assign active    = (state != IDLE);

  always_ff @(posedge clkin) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n      = state;
    core_en      = 1'b0;
    core_start   = 1'b0;
    core_no_rise = 1'b0;
    apply        = 1'b0;
    case (state)
      IDLE: begin
        apply = pend_v;
        if (run) begin
          core_start = 1'b1;
          state_n    = RUN;
        end
      end
      RUN: begin
        core_en = 1'b1;
        // Ratio changes only on a 0->1 toggle so no runt phase is produced.
        apply   = pend_v & wrap & ~clkout;
        if (!run) begin
          state_n = STOP;
        end
      end
      STOP: begin
        core_en = 1'b1;
        if (run) begin
          // Resume without disturbing cnt or clkout.
          state_n = RUN;
          apply   = pend_v & wrap & ~clkout;
        end else begin
          core_no_rise = 1'b1;
          if (wrap) begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A word is accepted only while nothing is pending, so apply and accept
  // can never coincide.
  always_ff @(posedge clkin) begin
    if (rst) begin
      pend_q <= '0;
      pend_v <= 1'b0;
    end else if (apply) begin
      pend_v <= 1'b0;
    end else if (cfg_valid && !pend_v) begin
      pend_q <= cfg_half;
      pend_v <= 1'b1;
    end
  end

  clk_div_core #(
    .CNT_W    (CNT_W),
    .DIV_RESET(DIV_RESET)
  ) u_core (
    .clkin   (clkin),
    .rst     (rst),
    .en      (core_en),
    .start   (core_start),
    .no_rise (core_no_rise),
    .load    (apply),
    .load_val(pend_q),
    .wrap    (wrap),
    .clkout  (clkout),
    .tick    (tick)
  );

endmodule
